// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with WB->ID write-through bypass, stall/flush
// handling and a saturating stall-cycle counter.
module id_ex_pipe_reg #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_wr,
    input  logic [31:0]       wb_wd,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // A WB write to $0 is discarded by the register file, so it never forwards.
    logic        wb_live;
    logic        byp_a_hit, byp_b_hit;
    logic        ref_a_hit, ref_b_hit;
    logic [31:0] byp_a, byp_b;

    // Forwarding selects for the incoming operands and for a held instruction.
    always_comb begin
        wb_live   = wb_reg_write && (wb_wr != 5'd0);
        byp_a_hit = wb_live && (wb_wr == id_rs);
        byp_b_hit = wb_live && (wb_wr == id_rt);
        ref_a_hit = wb_live && (wb_wr == ex_rs);
        ref_b_hit = wb_live && (wb_wr == ex_rt);
        byp_a     = byp_a_hit ? wb_wd : id_rd1;
        byp_b     = byp_b_hit ? wb_wd : id_rd2;
    end

    // EX-side state: reset > flush > stall (hold with operand refresh) > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (stall) begin
            // A held instruction must still see a write that retires under it.
            if (ref_a_hit) ex_a <= wb_wd;
            if (ref_b_hit) ex_b <= wb_wd;
        end else begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_a     <= byp_a;
            ex_b     <= byp_b;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_ctrl;
        end
    end

    // Saturating count of stalled cycles; a flush cycle does not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (CNT_W=4 to reach saturation).
module tb_id_ex_pipe_reg;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n, stall, flush, id_valid;
    logic [4:0]        id_rs, id_rt, id_rd, wb_wr;
    logic [31:0]       id_rd1, id_rd2, id_imm, wb_wd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_reg_write;
    logic              ex_valid;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [31:0]       ex_a, ex_b, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_pipe_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_wr(wb_wr), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(ex_valid), 32'd0);
        chk({tag, " rs"},    32'(ex_rs),    32'd0);
        chk({tag, " rt"},    32'(ex_rt),    32'd0);
        chk({tag, " rd"},    32'(ex_rd),    32'd0);
        chk({tag, " a"},     ex_a,          32'd0);
        chk({tag, " b"},     ex_b,          32'd0);
        chk({tag, " imm"},   ex_imm,        32'd0);
        chk({tag, " ctrl"},  32'(ex_ctrl),  32'd0);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [7:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] wr, input logic [31:0] wd);
        wb_reg_write = we; wb_wr = wr; wb_wd = wd;
    endtask

    initial begin
        // Reset with busy inputs
        rst_n = 1'b0; stall = 1'b1; flush = 1'b0;
        set_id(1'b1, 5'd7, 5'd8, 5'd9, 32'hAAAA5555, 32'h12345678, 32'hDEADBEEF, 8'hFF);
        set_wb(1'b1, 5'd7, 32'h00C0FFEE);
        tick();
        chk_zero("reset1");
        chk("reset1 cnt", 32'(stall_cnt), 32'd0);
        tick();
        chk_zero("reset2");
        chk("reset2 cnt", 32'(stall_cnt), 32'd0);

        // Plain load
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 5'd2, 5'd3, 5'd4, 32'd23, 32'd28, 32'hFFFFFFFC, 8'h81);
        set_wb(1'b0, 5'd0, 32'd0);
        tick();
        chk("load a", ex_a, 32'd23);
        chk("load b", ex_b, 32'd28);
        chk("load imm", ex_imm, 32'hFFFFFFFC);
        chk("load ctrl", 32'(ex_ctrl), 32'h81);
        chk("load valid", 32'(ex_valid), 32'd1);
        chk("load rs", 32'(ex_rs), 32'd2);
        chk("load rt", 32'(ex_rt), 32'd3);
        chk("load rd", 32'(ex_rd), 32'd4);
        chk("load cnt", 32'(stall_cnt), 32'd0);

        // Bypass on rs
        set_wb(1'b1, 5'd2, 32'd55);
        tick();
        chk("byp a", ex_a, 32'd55);
        chk("byp b untouched", ex_b, 32'd28);

        // Write enable low: no bypass
        set_wb(1'b0, 5'd2, 32'd55);
        tick();
        chk("byp we0 a", ex_a, 32'd23);

        // $0 never bypassed
        set_id(1'b1, 5'd0, 5'd3, 5'd4, 32'd0, 32'd28, 32'd1, 8'h81);
        set_wb(1'b1, 5'd0, 32'd55);
        tick();
        chk("byp r0 a", ex_a, 32'd0);
        chk("byp r0 b", ex_b, 32'd28);

        // rs == rt, both bypassed
        set_id(1'b1, 5'd2, 5'd2, 5'd4, 32'd23, 32'd23, 32'd1, 8'h81);
        set_wb(1'b1, 5'd2, 32'd55);
        tick();
        chk("byp rsrt a", ex_a, 32'd55);
        chk("byp rsrt b", ex_b, 32'd55);

        // Stall with refresh: load rs=1 a=7
        set_id(1'b1, 5'd1, 5'd5, 5'd6, 32'd7, 32'd8, 32'd10, 8'h01);
        set_wb(1'b0, 5'd0, 32'd0);
        tick();
        chk("pre-stall a", ex_a, 32'd7);
        stall = 1'b1;
        set_id(1'b0, 5'd9, 5'd10, 5'd11, 32'd111, 32'd222, 32'd333, 8'hFF);
        tick();
        chk("stall1 a", ex_a, 32'd7);
        chk("stall1 rs", 32'(ex_rs), 32'd1);
        chk("stall1 cnt", 32'(stall_cnt), 32'd1);
        set_wb(1'b1, 5'd1, 32'd99);
        tick();
        chk("stall2 refresh a", ex_a, 32'd99);
        chk("stall2 b", ex_b, 32'd8);
        chk("stall2 cnt", 32'(stall_cnt), 32'd2);
        set_wb(1'b0, 5'd0, 32'd0);
        tick();
        chk("stall3 a", ex_a, 32'd99);
        chk("stall3 rs", 32'(ex_rs), 32'd1);
        chk("stall3 rt", 32'(ex_rt), 32'd5);
        chk("stall3 rd", 32'(ex_rd), 32'd6);
        chk("stall3 imm", ex_imm, 32'd10);
        chk("stall3 ctrl", 32'(ex_ctrl), 32'h01);
        chk("stall3 valid", 32'(ex_valid), 32'd1);
        chk("stall3 cnt", 32'(stall_cnt), 32'd3);

        // Flush overrides stall, counter untouched
        flush = 1'b1;
        tick();
        chk_zero("flush");
        chk("flush cnt", 32'(stall_cnt), 32'd3);

        // Normal capture resumes
        flush = 1'b0; stall = 1'b0;
        set_id(1'b1, 5'd6, 5'd7, 5'd8, 32'd60, 32'd70, 32'd5, 8'h03);
        tick();
        chk("reload a", ex_a, 32'd60);
        chk("reload b", ex_b, 32'd70);
        chk("reload valid", 32'(ex_valid), 32'd1);
        chk("reload ctrl", 32'(ex_ctrl), 32'h03);
        chk("reload cnt", 32'(stall_cnt), 32'd3);

        // Invalid load still copies fields
        set_id(1'b0, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd3, 8'h04);
        tick();
        chk("inv valid", 32'(ex_valid), 32'd0);
        chk("inv a", ex_a, 32'd1);
        chk("inv ctrl", 32'(ex_ctrl), 32'h04);

        // Saturation: 20 stall cycles from 3
        stall = 1'b1;
        repeat (20) tick();
        chk("sat cnt", 32'(stall_cnt), 32'd15);
        tick();
        chk("sat hold cnt", 32'(stall_cnt), 32'd15);
        chk("sat hold a", ex_a, 32'd1);

        // Reset during stall
        rst_n = 1'b0;
        tick();
        chk_zero("mid reset");
        chk("mid reset cnt", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
